// File: rtl/mc_ctrl_fsm_if.sv
// Control bus between the multicycle FSM and the datapath: status in, clock-enables and selects out.
// Master is the control unit; slave is the datapath side.
interface mc_ctrl_fsm_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_ce;
    logic       ir_ce;
    logic       mdr_ce;
    logic       aluout_ce;
    logic       mem_rd;
    logic       mem_wr;
    logic       iord;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alusrc_a;
    logic [1:0] alusrc_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic [3:0] state;
    logic       illegal;
    logic       mem_err;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_ce, ir_ce, mdr_ce, aluout_ce, mem_rd, mem_wr, iord, reg_we, reg_dst,
               mem_to_reg, alusrc_a, alusrc_b, alu_op, pc_src, state, illegal, mem_err
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_ce, ir_ce, mdr_ce, aluout_ce, mem_rd, mem_wr, iord, reg_we, reg_dst,
               mem_to_reg, alusrc_a, alusrc_b, alu_op, pc_src, state, illegal, mem_err
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM: sequences datapath CEs/selects through fetch/decode/execute/memory/writeback.
// Latency: Moore outputs from the state register (BR pc_ce follows zero); lw 5, sw/R/addi 4, beq/j 3 cycles.
// Backpressure: mem_ready stalls IF/MRD/MWR; MEM_TO stalled cycles abandon the access. MC_CTRL_HALT_EN adds HALT.
module mc_ctrl_fsm #(
    parameter int MEM_TO = 15,
    parameter int CNT_W  = 4
) (
    input logic           clk,
    input logic           rst_n,
    mc_ctrl_fsm_if.master bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam bit               TO_EN  = (MEM_TO != 0);
    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(MEM_TO);

    typedef enum logic [3:0] {
        S_IF    = 4'd0,
        S_ID    = 4'd1,
        S_MADDR = 4'd2,
        S_MRD   = 4'd3,
        S_MWB   = 4'd4,
        S_MWR   = 4'd5,
        S_REX   = 4'd6,
        S_RWB   = 4'd7,
        S_BR    = 4'd8,
        S_JMP   = 4'd9,
        S_IEX   = 4'd10,
        S_IWB   = 4'd11
`ifdef MC_CTRL_HALT_EN
        , S_HALT = 4'd12
`endif
    } state_t;

`ifdef MC_CTRL_HALT_EN
    localparam state_t S_ABORT = S_HALT;
`else
    localparam state_t S_ABORT = S_IF;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             mem_wait;
    logic             timeout;
    logic             op_legal;
    logic             unused_funct;

    assign unused_funct = ^bus.funct;
    assign mem_wait     = (state_q == S_IF) || (state_q == S_MRD) || (state_q == S_MWR);
    // Completion wins over the timeout when both land on the same cycle.
    assign timeout      = TO_EN && mem_wait && !bus.mem_ready && (cnt_q == TO_CNT);
    assign op_legal     = (bus.opcode == OP_LW) || (bus.opcode == OP_SW) || (bus.opcode == OP_RTYPE) ||
                          (bus.opcode == OP_BEQ) || (bus.opcode == OP_J) || (bus.opcode == OP_ADDI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IF;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (mem_wait) begin
            if (bus.mem_ready) begin
                cnt_d = '0;
            end else if (timeout) begin
                cnt_d = '0;
                err_d = 1'b1;
            end else if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        case (state_q)
            S_IF:    if (bus.mem_ready) state_d = S_ID;  else if (timeout) state_d = S_ABORT;
            S_ID: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MADDR;
                    OP_RTYPE:     state_d = S_REX;
                    OP_BEQ:       state_d = S_BR;
                    OP_J:         state_d = S_JMP;
                    OP_ADDI:      state_d = S_IEX;
                    default:      state_d = S_ABORT;
                endcase
            end
            S_MADDR: state_d = (bus.opcode == OP_SW) ? S_MWR : S_MRD;
            S_MRD:   if (bus.mem_ready) state_d = S_MWB; else if (timeout) state_d = S_ABORT;
            S_MWR:   if (bus.mem_ready) state_d = S_IF;  else if (timeout) state_d = S_ABORT;
            S_REX:   state_d = S_RWB;
            S_IEX:   state_d = S_IWB;
`ifdef MC_CTRL_HALT_EN
            S_HALT:  state_d = S_HALT;
`endif
            default: state_d = S_IF;
        endcase
    end

    assign bus.state   = state_q;
    assign bus.mem_err = err_q;

    always_comb begin
        bus.pc_ce      = 1'b0;
        bus.ir_ce      = 1'b0;
        bus.mdr_ce     = 1'b0;
        bus.aluout_ce  = 1'b0;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.iord       = 1'b0;
        bus.reg_we     = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alusrc_a   = 1'b0;
        bus.alusrc_b   = 2'd0;
        bus.alu_op     = 2'd0;
        bus.pc_src     = 2'd0;
        bus.illegal    = 1'b0;
        case (state_q)
            S_IF: begin
                // Held in reset the fetch must not latch IR or advance PC.
                bus.mem_rd   = 1'b1;
                bus.alusrc_b = 2'd1;
                bus.ir_ce    = bus.mem_ready & rst_n;
                bus.pc_ce    = bus.mem_ready & rst_n;
            end
            S_ID: begin
                bus.alusrc_b  = 2'd3;
                bus.aluout_ce = 1'b1;
                bus.illegal   = !op_legal;
            end
            S_MADDR, S_IEX: begin
                bus.alusrc_a  = 1'b1;
                bus.alusrc_b  = 2'd2;
                bus.aluout_ce = 1'b1;
            end
            S_MRD: begin
                bus.mem_rd = 1'b1;
                bus.iord   = 1'b1;
                bus.mdr_ce = bus.mem_ready;
            end
            S_MWB: begin
                bus.reg_we     = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_MWR: begin
                bus.mem_wr = 1'b1;
                bus.iord   = 1'b1;
            end
            S_REX: begin
                bus.alusrc_a  = 1'b1;
                bus.alu_op    = 2'd2;
                bus.aluout_ce = 1'b1;
            end
            S_RWB: begin
                bus.reg_we  = 1'b1;
                bus.reg_dst = 1'b1;
            end
            S_BR: begin
                bus.alusrc_a = 1'b1;
                bus.alu_op   = 2'd1;
                bus.pc_src   = 2'd1;
                bus.pc_ce    = bus.zero;
            end
            S_JMP: begin
                bus.pc_src = 2'd2;
                bus.pc_ce  = 1'b1;
            end
            S_IWB:   bus.reg_we = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: per-instruction route model checked every cycle, plus directed literal pins.
module tb_mc_ctrl_fsm;
    localparam int MEM_TO = 15;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mc_ctrl_fsm_if bus ();
    mc_ctrl_fsm #(.MEM_TO(MEM_TO), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct packed {
        logic       pc_ce, ir_ce, mdr_ce, aluout_ce, mem_rd, mem_wr, iord;
        logic       reg_we, reg_dst, mem_to_reg, alusrc_a;
        logic [1:0] alusrc_b, alu_op, pc_src;
        logic [3:0] state;
        logic       illegal, mem_err;
    } ctl_t;

    int         n_pass = 0;
    int         n_total = 0;
    ctl_t       last;
    logic [5:0] cur_op;

    // Model: the list of spec states an instruction walks through, a wait count and the error flag.
    int m_route[$];
    int m_pos;
    int m_wait;
    bit m_err, m_halt, m_illegal;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic int cur_step();
        return m_halt ? 12 : m_route[m_pos];
    endfunction

    function automatic void go_if();
        m_route = '{0};
        m_pos   = 0;
    endfunction

    function automatic void model_reset();
        go_if();
        m_wait = 0; m_err = 0; m_halt = 0; m_illegal = 0;
    endfunction

    function automatic void load_route(logic [5:0] op);
        m_illegal = 0;
        case (op)
            6'b100011: m_route = '{0, 1, 2, 3, 4};
            6'b101011: m_route = '{0, 1, 2, 5};
            6'b000000: m_route = '{0, 1, 6, 7};
            6'b000100: m_route = '{0, 1, 8};
            6'b000010: m_route = '{0, 1, 9};
            6'b001000: m_route = '{0, 1, 10, 11};
            default:   begin m_route = '{0, 1}; m_illegal = 1; end
        endcase
        m_pos = 0;
    endfunction

    function automatic void next_step();
        m_pos++;
        if (m_pos >= m_route.size()) go_if();
    endfunction

    function automatic void abort_instr();
`ifdef MC_CTRL_HALT_EN
        m_halt = 1;
`else
        go_if();
`endif
    endfunction

    function automatic ctl_t base(int s);
        ctl_t b = '0;
        b.state = 4'(s);
        case (s)
            0:  begin b.mem_rd = 1; b.alusrc_b = 2'd1; end
            1:  begin b.alusrc_b = 2'd3; b.aluout_ce = 1; end
            2:  begin b.alusrc_a = 1; b.alusrc_b = 2'd2; b.aluout_ce = 1; end
            3:  begin b.mem_rd = 1; b.iord = 1; end
            4:  begin b.reg_we = 1; b.mem_to_reg = 1; end
            5:  begin b.mem_wr = 1; b.iord = 1; end
            6:  begin b.alusrc_a = 1; b.alu_op = 2'd2; b.aluout_ce = 1; end
            7:  begin b.reg_we = 1; b.reg_dst = 1; end
            8:  begin b.alusrc_a = 1; b.alu_op = 2'd1; b.pc_src = 2'd1; end
            9:  begin b.pc_src = 2'd2; b.pc_ce = 1; end
            10: begin b.alusrc_a = 1; b.alusrc_b = 2'd2; b.aluout_ce = 1; end
            11: b.reg_we = 1;
            default: ;
        endcase
        return b;
    endfunction

    function automatic ctl_t exp_ctl(logic mr, logic z);
        int   s = cur_step();
        ctl_t e = base(s);
        e.mem_err = m_err;
        if (s == 0) begin e.ir_ce = mr; e.pc_ce = mr; end
        if (s == 3) e.mdr_ce = mr;
        if (s == 8) e.pc_ce = z;
        if (s == 1) e.illegal = m_illegal;
        return e;
    endfunction

    function automatic void m_advance(logic mr);
        int s = cur_step();
        if (s == 12) return;
        if (s == 0 || s == 3 || s == 5) begin
            if (mr) begin
                m_wait = 0;
                if (s == 0) load_route(bus.opcode);
                next_step();
            end else if (MEM_TO != 0 && m_wait == MEM_TO) begin
                m_wait = 0; m_err = 1; abort_instr();
            end else begin
                m_wait++;
            end
        end else if (s == 1 && m_illegal) begin
            abort_instr();
        end else begin
            next_step();
        end
    endfunction

    function automatic ctl_t dut_ctl();
        ctl_t d;
        d.pc_ce = bus.pc_ce; d.ir_ce = bus.ir_ce; d.mdr_ce = bus.mdr_ce; d.aluout_ce = bus.aluout_ce;
        d.mem_rd = bus.mem_rd; d.mem_wr = bus.mem_wr; d.iord = bus.iord; d.reg_we = bus.reg_we;
        d.reg_dst = bus.reg_dst; d.mem_to_reg = bus.mem_to_reg; d.alusrc_a = bus.alusrc_a;
        d.alusrc_b = bus.alusrc_b; d.alu_op = bus.alu_op; d.pc_src = bus.pc_src;
        d.state = bus.state; d.illegal = bus.illegal; d.mem_err = bus.mem_err;
        return d;
    endfunction

    // One clock: drive inputs after the falling edge, compare against the model, then advance it.
    task automatic step(input logic mr, input logic z);
        ctl_t e;
        @(negedge clk);
        if (cur_step() == 0) bus.opcode = cur_op;
        bus.mem_ready = mr;
        bus.zero      = z;
        bus.funct     = 6'($urandom);
        #1;
        e    = exp_ctl(mr, z);
        last = dut_ctl();
        chk($sformatf("cycle_model st=%0d", cur_step()), {9'd0, last}, {9'd0, e});
        m_advance(mr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        model_reset();
        chk("rst_state",   32'(bus.state),   32'd0);
        chk("rst_pc_ce",   32'(bus.pc_ce),   32'd0);
        chk("rst_ir_ce",   32'(bus.ir_ce),   32'd0);
        chk("rst_mem_rd",  32'(bus.mem_rd),  32'd1);
        chk("rst_mem_err", 32'(bus.mem_err), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic peek_if(input string nm);
        step(1'b0, 1'b0);
        chk(nm, 32'(last.state), 32'd0);
    endtask

    logic [31:0] seq, we_bits, dst_bits, pcce_bits, mdr_bits;
    int          cnt_a, n, ir_seen, halt_cnt, thr;
    logic [7:0]  lw_pat;
    logic [5:0]  op_tab [6];

    initial begin
        rst_n = 1'b0;
        bus.opcode = '0; bus.funct = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        cur_op = '0;
        op_tab = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
        model_reset();
        do_reset();

        // R-type: 0,1,6,7 then back in IF
        cur_op = 6'b000000;
        seq = '0; we_bits = '0; dst_bits = '0; pcce_bits = '0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0);
            seq       = {seq[27:0], last.state};
            we_bits   = {we_bits[30:0], last.reg_we};
            dst_bits  = {dst_bits[30:0], last.reg_dst};
            pcce_bits = {pcce_bits[30:0], last.pc_ce};
        end
        chk("rtype_states", seq, 32'h0167);
        chk("rtype_reg_we", we_bits, 32'b0001);
        chk("rtype_reg_dst", dst_bits, 32'b0001);
        chk("rtype_pc_ce", pcce_bits, 32'b1000);
        peek_if("rtype_back_to_if");

        // lw with three stalled MRD cycles
        cur_op = 6'b100011;
        lw_pat = 8'b1110_0011;
        cnt_a = 0; mdr_bits = '0;
        for (int i = 0; i < 8; i++) begin
            step(lw_pat[7-i], 1'b0);
            if (last.state == 4'd3 && last.mem_rd) cnt_a++;
            mdr_bits = {mdr_bits[30:0], last.mdr_ce};
        end
        chk("lw_mem_rd_cycles", 32'(cnt_a), 32'd4);
        chk("lw_mdr_ce_on_ready", mdr_bits, 32'b0000_0010);
        chk("lw_mem_err", 32'(last.mem_err), 32'd0);
        peek_if("lw_total_8_cycles");

        // beq taken / not taken
        cur_op = 6'b000100;
        seq = '0;
        for (int i = 0; i < 3; i++) begin step(1'b1, 1'b1); seq = {seq[27:0], last.state}; end
        chk("beq_states", seq, 32'h018);
        chk("beq_taken_pc_ce", 32'(last.pc_ce), 32'd1);
        chk("beq_taken_pc_src", 32'(last.pc_src), 32'd1);
        peek_if("beq_taken_3_cycles");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        chk("beq_not_taken_pc_ce", 32'(last.pc_ce), 32'd0);
        peek_if("beq_not_taken_3_cycles");

        // unsupported opcode
        cur_op = 6'b111111;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("illegal_pulse", 32'(last.illegal), 32'd1);
        chk("illegal_in_id", 32'(last.state), 32'd1);
        step(1'b0, 1'b0);
        chk("illegal_one_cycle", 32'(last.illegal), 32'd0);
`ifdef MC_CTRL_HALT_EN
        for (int i = 0; i < 20; i++) begin
            chk("halt_state", 32'(last.state), 32'd12);
            chk("halt_ces", 32'({last.pc_ce, last.ir_ce, last.mdr_ce, last.aluout_ce}), 32'd0);
            step(1'b1, 1'b0);
        end
        do_reset();
`else
        chk("illegal_to_if", 32'(last.state), 32'd0);
`endif

        // sw stalled in MWR, reset pulsed between clock edges
        cur_op = 6'b101011;
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
        step(1'b0, 1'b0); step(1'b0, 1'b0);
        chk("sw_in_mwr", 32'(last.state), 32'd5);
        chk("sw_mem_wr", 32'(last.mem_wr), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(bus.state), 32'd0);
        chk("async_rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        chk("async_rst_mem_err", 32'(bus.mem_err), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();

        // fetch timeout
        n = 0; ir_seen = 0;
        do begin
            step(1'b0, 1'b0);
            n++;
            if (last.ir_ce) ir_seen++;
        end while (!last.mem_err && n < 40);
        chk("timeout_cycles_to_err", 32'(n), 32'd17);
        chk("timeout_no_ir_ce", 32'(ir_seen), 32'd0);
`ifdef MC_CTRL_HALT_EN
        chk("timeout_state", 32'(last.state), 32'd12);
`else
        chk("timeout_state", 32'(last.state), 32'd0);
`endif
        do_reset();

        // randomized traffic
        halt_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if (cur_step() == 0) begin
                n = $urandom_range(0, 7);
                cur_op = (n < 6) ? op_tab[n] : ((n == 6) ? 6'b111111 : 6'($urandom));
            end
            thr = (i >= 1200 && i < 1400) ? 1 : 7;
            step(($urandom_range(0, 9) < thr) ? 1'b1 : 1'b0, 1'($urandom));
            if (m_halt) halt_cnt++;
            if (halt_cnt > 5 || $urandom_range(0, 499) == 0) begin
                do_reset();
                halt_cnt = 0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle control unit for the 32-bit datapath.
- Sequences the clock-enables of the PC, IR, MDR and ALUOut 32-bit registers, plus the memory, register-file and mux selects, through fetch/decode/execute/memory/writeback.
- Handles a variable-latency memory through a ready handshake.
- Sits beside the datapath; the top level wires its outputs to the CE pins and mux selects.

Parameters:
- MEM_TO, 15: max wait cycles for mem_ready before `mem_err` is raised. 0 disables the timeout.
- CNT_W, 4: width of the wait counter. Must hold MEM_TO.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current access this cycle.
- pc_ce  out  1  PC register CE.
- ir_ce  out  1  IR register CE.
- mdr_ce  out  1  MDR register CE.
- aluout_ce  out  1  ALUOut register CE.
- mem_rd  out  1  memory read request.
- mem_wr  out  1  memory write request.
- iord  out  1  address select: 0 = PC, 1 = ALUOut.
- reg_we  out  1  register-file write enable.
- reg_dst  out  1  write-register select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write-data select: 0 = ALUOut, 1 = MDR.
- alusrc_a  out  1  ALU A select: 0 = PC, 1 = A.
- alusrc_b  out  2  ALU B select: 0 = B, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm<<2.
- alu_op  out  2  ALU op: 0 = add, 1 = sub, 2 = funct-decoded.
- pc_src  out  2  next-PC select: 0 = ALU, 1 = ALUOut, 2 = jump target.
- state  out  4  current state, for debug.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- mem_err  out  1  sticky flag: memory timeout occurred.

Behaviour:
- Reset (rst_n = 0, async):
  - state = IF(0), wait counter = 0, mem_err = 0.
  - All outputs are decoded from IF, except ir_ce = 0 and pc_ce = 0.
  - Reset asserted mid-access aborts the access immediately. No partial register write occurs.
- Outputs are Moore-decoded from the state register. The only exception: in BR, pc_ce = zero.
- Default value of every output in every state is 0.
- States and transitions:
  - IF(0): mem_rd = 1, iord = 0, alusrc_a = 0, alusrc_b = 1, alu_op = 0, pc_src = 0.
    - ir_ce and pc_ce = mem_ready.
    - Stays in IF while !mem_ready; goes to ID when mem_ready.
  - ID(1): alusrc_a = 0, alusrc_b = 3, aluout_ce = 1 (branch target). Decodes opcode:
    - 100011 (lw) and 101011 (sw) → MADDR.
    - 000000 (R-type) → REX.
    - 000100 (beq) → BR.
    - 000010 (j) → JMP.
    - 001000 (addi) → IEX.
    - Any other opcode → illegal = 1 for one cycle, then IF.
  - MADDR(2): alusrc_a = 1, alusrc_b = 2, aluout_ce = 1. Goes to MRD for lw, MWR for sw.
  - MRD(3): mem_rd = 1, iord = 1, mdr_ce = mem_ready. Waits like IF, then → MWB.
  - MWB(4): reg_we = 1, reg_dst = 0, mem_to_reg = 1. → IF.
  - MWR(5): mem_wr = 1, iord = 1. Waits like IF, then → IF.
  - REX(6): alusrc_a = 1, alusrc_b = 0, alu_op = 2, aluout_ce = 1. → RWB.
  - RWB(7): reg_we = 1, reg_dst = 1, mem_to_reg = 0. → IF.
  - BR(8): alusrc_a = 1, alusrc_b = 0, alu_op = 1, pc_src = 1, pc_ce = zero. → IF.
  - JMP(9): pc_src = 2, pc_ce = 1. → IF.
  - IEX(10): alusrc_a = 1, alusrc_b = 2, alu_op = 0, aluout_ce = 1. → IWB.
  - IWB(11): reg_we = 1, reg_dst = 0, mem_to_reg = 0. → IF.
- Memory wait (IF, MRD, MWR):
  - Wait counter increments on each cycle with mem_ready = 0. It clears on leaving the state.
  - If MEM_TO ≠ 0 and the counter reaches MEM_TO: mem_err is set (sticky until reset), the access is abandoned, next state = IF.
  - No CE is asserted on the abandon cycle.
  - mem_ready high on the same cycle the count reaches MEM_TO: completion wins.
- Cycle counts with zero-wait memory:
  - lw: 5 cycles.
  - sw, R-type, addi: 4 cycles.
  - beq, j: 3 cycles.
- funct is passed through to the ALU decoder only. The FSM ignores it.

Optional Feature:
- Macro: MC_CTRL_HALT_EN.
- Defined:
  - Adds state HALT(12).
  - An unsupported opcode in ID, or a memory timeout, goes to HALT instead of IF.
  - In HALT all outputs are 0; only rst_n exits.
  - illegal still pulses on the ID cycle.
- Undefined: HALT does not exist; behaviour is as in Behaviour above.

Test Plan:
- rst_n = 0 → 1, mem_ready = 1, opcode = 000000 → state sequence 0, 1, 6, 7, 0. reg_we = 1 and reg_dst = 1 only in state 7. pc_ce = 1 only in state 0.
- lw (100011) with mem_ready low for 3 cycles in MRD → mem_rd held 4 cycles, mdr_ce = 1 only on the ready cycle, total 8 cycles, mem_err = 0.
- beq (000100): with zero = 1, pc_ce = 1 and pc_src = 1 in BR. With zero = 0, pc_ce = 0. Both return to IF after 3 cycles.
- opcode = 111111 → illegal pulses 1 cycle in ID, next state = IF. With MC_CTRL_HALT_EN: state = 12 and stays there; all CEs 0 for 20 cycles.
- MEM_TO = 15, mem_ready held 0 in IF → mem_err = 1 after 15 wait cycles, ir_ce never asserted, re-enters IF.
- sw in MWR, rst_n pulsed low for 1 cycle → state = 0 asynchronously, mem_wr drops without waiting for clk, mem_err = 0.
